// File: rtl/game_pkg.sv
// Shared constants for the VGA game datapath: sine table geometry and
// fixed requester indices of the wave generators.
package game_pkg;

    localparam int POS_W       = 4;
    localparam int DATA_W      = 8;
    localparam int MAX_REQ     = 4;
    localparam int REQ_TOP_SIN = 0;
    localparam int REQ_BOT_SIN = 1;

    typedef logic [1:0] req_id_t;

endpackage

// File: rtl/sine_lut.sv
// 16-entry unsigned sine table: 128 + 127*sin(2*pi*k/16), rounded.
// Purely combinational; the arbiter registers the result.
module sine_lut
    import game_pkg::*;
(
    input  logic [POS_W-1:0]  pos,
    output logic [DATA_W-1:0] data
);

    localparam logic [DATA_W-1:0] TBL [16] = '{
        8'd128, 8'd177, 8'd218, 8'd245,
        8'd255, 8'd245, 8'd218, 8'd177,
        8'd128, 8'd79,  8'd38,  8'd11,
        8'd1,   8'd11,  8'd38,  8'd79
    };

    assign data = TBL[pos];

endmodule

// File: rtl/sine_lut_arbiter.sv
// Shares one sine_lut between NUM_REQ wave generators, 1-cycle response.
// Define SINE_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module sine_lut_arbiter
#(
    parameter int NUM_REQ = 2,
    parameter int POS_W   = 4,
    parameter int DATA_W  = 8
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*POS_W-1:0] req_pos,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [DATA_W-1:0]        rsp_data
);
    import game_pkg::*;

    logic [NUM_REQ-1:0] grant;
    logic               gnt_any;
    req_id_t            gnt_id;
    logic [POS_W-1:0]   gnt_pos;
    logic [DATA_W-1:0]  lut_data;

    logic               rsp_valid_q, rsp_valid_d;
    req_id_t            rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

`ifdef SINE_ARB_FIXED_PRIO_EN
    function automatic logic [NUM_REQ-1:0] fp_grant(
        input logic [NUM_REQ-1:0] v
    );
        logic found;
        fp_grant = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && v[i]) begin
                fp_grant[i] = 1'b1;
                found       = 1'b1;
            end
        end
    endfunction

    always_comb grant = fp_grant(req_valid);
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Scan from ptr upward, wrapping at NUM_REQ; first valid wins.
    function automatic logic [NUM_REQ-1:0] rr_grant(
        input logic [NUM_REQ-1:0] v,
        input logic [1:0]         ptr
    );
        int   idx;
        logic found;
        rr_grant = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && v[idx]) begin
                rr_grant[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    endfunction

    always_comb grant = rr_grant(req_valid, rr_ptr_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            if (int'(gnt_id) + 1 >= NUM_REQ) rr_ptr_d = 2'd0;
            else                             rr_ptr_d = gnt_id + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 2'd0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Gate with rst_n so nothing looks granted while reset is held.
    assign req_ready = grant & {NUM_REQ{en & rst_n}};
    assign gnt_any   = |req_ready;

    always_comb begin
        gnt_id  = '0;
        gnt_pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_id  = req_id_t'(i);
                gnt_pos = req_pos[i*POS_W +: POS_W];
            end
        end
    end

    sine_lut u_lut (
        .pos  (gnt_pos),
        .data (lut_data)
    );

    always_comb begin
        rsp_valid_d = gnt_any;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (gnt_any) begin
            rsp_id_d   = gnt_id;
            rsp_data_d = lut_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Directed bench for sine_lut_arbiter (NUM_REQ=2); inputs change on the
// falling edge, req_ready is sampled mid-cycle, responses 1ns after rise.
module tb_sine_lut_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] req_valid;
    logic [7:0] req_pos;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [7:0] rsp_data;

    int errors = 0;
    int checks = 0;

    // Reference samples: 128 + 127*sin(2*pi*k/16)
    localparam logic [7:0] S2 = 8'd218;
    localparam logic [7:0] S4 = 8'd255;
    localparam logic [7:0] S7 = 8'd177;
    localparam logic [7:0] S9 = 8'd79;

    sine_lut_arbiter #(.NUM_REQ(2), .POS_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_pos   (req_pos),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 2'b11;
        req_pos   = {4'd9, 4'd2};
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready: got %b want 00", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid: got %b want 0", rsp_valid);
        end
        checks++;
        if (rsp_data !== 8'd0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_data: got %0d/%0d want 0/0", rsp_data, rsp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL first_grant: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== S2) begin
            errors++;
            $display("FAIL first_rsp: got v%b id%0d d%0d want v1 id0 d%0d",
                     rsp_valid, rsp_id, rsp_data, S2);
        end
    endtask

    task automatic test_single;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 2'b10;
            req_pos   = {4'd4, 4'd0};
            #1;
            checks++;
            if (req_ready !== 2'b10) begin
                errors++;
                $display("FAIL single_ready%0d: got %b want 10", c, req_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== S4) begin
                errors++;
                $display("FAIL single_rsp%0d: got v%b id%0d d%0d want v1 id1 d%0d",
                         c, rsp_valid, rsp_id, rsp_data, S4);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready: got %b want 00", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd1 || rsp_data !== S4) begin
            errors++;
            $display("FAIL idle_hold: got v%b id%0d d%0d want v0 id1 d%0d",
                     rsp_valid, rsp_id, rsp_data, S4);
        end
    endtask

    task automatic test_contention;
        logic [1:0] eg;
        logic [1:0] eid;
        logic [7:0] ed;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 2'b11;
            req_pos   = {4'd9, 4'd2};
`ifdef SINE_ARB_FIXED_PRIO_EN
            eg = 2'b01;
`else
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
            eid = (eg == 2'b01) ? 2'd0 : 2'd1;
            ed  = (eg == 2'b01) ? S2 : S9;
            #1;
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL cont_ready%0d: got %b want %b", c, req_ready, eg);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_data !== ed) begin
                errors++;
                $display("FAIL cont_rsp%0d: got v%b id%0d d%0d want v1 id%0d d%0d",
                         c, rsp_valid, rsp_id, rsp_data, eid, ed);
            end
        end
        // req0 drops: req1 gets through in either build
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL cont_drop: got %b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_enable;
        logic [1:0] eg;
        // rr_ptr is 0 here; this grant moves it to 1
        @(negedge clk);
        en        = 1'b1;
        req_valid = 2'b11;
        req_pos   = {4'd9, 4'd2};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL en_pre: got %b want 01", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            en = 1'b0;
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL en_gate%0d: got %b want 00", c, req_ready);
            end
            if (c == 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== S2) begin
                    errors++;
                    $display("FAIL en_inflight: got v%b id%0d d%0d want v1 id0 d%0d",
                             rsp_valid, rsp_id, rsp_data, S2);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_norsp%0d: got %b want 0", c, rsp_valid);
            end
        end
        @(negedge clk);
        en = 1'b1;
`ifdef SINE_ARB_FIXED_PRIO_EN
        eg = 2'b01;
`else
        eg = 2'b10;
`endif
        #1;
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL en_resume: got %b want %b", req_ready, eg);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_midreset;
        // rr_ptr is 0 again in the round-robin build
        @(negedge clk);
        req_valid = 2'b01;
        req_pos   = {4'd0, 4'd7};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mr_grant: got %b want 01", req_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL mr_async: got v%b r%b want v0 r00", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL mr_discard: got v%b id%0d d%0d want v0 id0 d0",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mr_ptr: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== S7) begin
            errors++;
            $display("FAIL mr_rsp: got v%b id%0d d%0d want v1 id0 d%0d",
                     rsp_valid, rsp_id, rsp_data, S7);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_enable();
        test_midreset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
